// File: rtl/ee354_project_ctrl.sv
// ee354_project_ctrl: game FSM, move-tick generator and 2-deep turn queue feeding the snake length stage.
module ee354_project_ctrl #(
   parameter int         TICK_DIV   = 25000000,
   parameter int         CNT_W      = 25,
   parameter logic [7:0] WIN_LENGTH = 8'd225
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Btn_U,
   input  logic       Btn_D,
   input  logic       Btn_L,
   input  logic       Btn_R,
   input  logic [7:0] Length,
   input  logic       Collision,
   output logic       q_I,
   output logic       q_Run,
   output logic       q_Win,
   output logic       q_Lose,
   output logic       Move_Tick,
   output logic [1:0] In_Dirn,
   output logic       SCEN
);
   typedef enum logic [3:0] {I = 4'b0001, RUN = 4'b0010, WIN = 4'b0100, LOSE = 4'b1000} state_t;
   state_t state, state_n;
   logic [CNT_W-1:0] move_cnt;
   logic [1:0] que0, que1, q_cnt, ref_dirn, req;
   logic run, go, tick, deq, req_v, acc;
   assign {q_Lose, q_Win, q_Run, q_I} = state;
   assign run = state == RUN;
   assign go = state == I && Start;
   assign tick = run && move_cnt == CNT_W'(TICK_DIV - 1);
   assign deq = tick && q_cnt != 2'd0;
   assign req_v = Btn_U | Btn_D | Btn_L | Btn_R;
   assign req = Btn_U ? 2'b00 : Btn_D ? 2'b01 : Btn_L ? 2'b10 : 2'b11;
   // Newest entry is the reference whether or not it leaves this cycle.
   assign ref_dirn = q_cnt == 2'd2 ? que1 : q_cnt == 2'd1 ? que0 : In_Dirn;
   assign acc = run && req_v && req[1] != ref_dirn[1] && !(q_cnt == 2'd2 && !deq);
   always_comb begin
      state_n = state;
      case (state)
         I:        state_n = Start ? RUN : I;
         RUN:      state_n = Collision ? LOSE : Length >= WIN_LENGTH ? WIN : RUN;
         WIN:      state_n = Start ? I : WIN;
         LOSE:     state_n = Start ? I : LOSE;
         default:  state_n = I;
      endcase
   end
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) state <= I;
      else state <= state_n;
   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         move_cnt  <= '0;
         Move_Tick <= 1'b0;
         SCEN      <= 1'b0;
         In_Dirn   <= 2'b00;
         que0      <= 2'b00;
         que1      <= 2'b00;
         q_cnt     <= 2'd0;
      end else begin
         Move_Tick <= tick;
         SCEN      <= deq;
         if (go) begin
            move_cnt <= '0;
            q_cnt    <= 2'd0;
            In_Dirn  <= 2'b00;
         end else if (run) begin
            move_cnt <= tick ? '0 : move_cnt + CNT_W'(1);
            if (deq) begin
               In_Dirn <= que0;
               que0    <= que1;
            end
            if (acc) begin
               if (q_cnt == {1'b0, deq}) que0 <= req;
               else que1 <= req;
            end
            q_cnt <= q_cnt - {1'b0, deq} + {1'b0, acc};
         end
      end
endmodule

// File: tb/tb_ee354_project_ctrl.sv
// tb_ee354_project_ctrl: directed bench for the game controller with TICK_DIV=4, WIN_LENGTH=5.
module tb_ee354_project_ctrl;
   logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Collision = 1'b0;
   logic Btn_U = 1'b0, Btn_D = 1'b0, Btn_L = 1'b0, Btn_R = 1'b0;
   logic [7:0] Length = 8'd0;
   logic q_I, q_Run, q_Win, q_Lose, Move_Tick, SCEN;
   logic [1:0] In_Dirn;
   int n_tests = 0, n_fail = 0;

   ee354_project_ctrl #(.TICK_DIV(4), .CNT_W(3), .WIN_LENGTH(8'd5)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Btn_U(Btn_U), .Btn_D(Btn_D),
      .Btn_L(Btn_L), .Btn_R(Btn_R), .Length(Length), .Collision(Collision),
      .q_I(q_I), .q_Run(q_Run), .q_Win(q_Win), .q_Lose(q_Lose),
      .Move_Tick(Move_Tick), .In_Dirn(In_Dirn), .SCEN(SCEN)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // {U,D,L,R} held for one clock
   task automatic press(input logic [3:0] b);
      {Btn_U, Btn_D, Btn_L, Btn_R} = b;
      step();
      {Btn_U, Btn_D, Btn_L, Btn_R} = 4'b0000;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      step();
      Start = 1'b0;
   endtask

   task automatic wait_tick(input string tag, input int exp_cyc, input logic [1:0] exp_dirn, input logic exp_scen);
      int n = 0;
      do begin
         step();
         n++;
      end while (!Move_Tick && n < 8);
      check({tag, "_cyc"}, n, exp_cyc);
      check({tag, "_dirn"}, In_Dirn, exp_dirn);
      check({tag, "_scen"}, SCEN, exp_scen);
   endtask

   initial begin
      step();
      step();
      Reset = 1'b0;
      check("rst_state", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
      check("rst_out", {Move_Tick, SCEN, In_Dirn}, 4'b0000);
      press(4'b1000);
      check("idle_btn", {q_I, In_Dirn, SCEN}, 4'b1000);
      pulse_start();
      check("run_state", {q_I, q_Run, q_Win, q_Lose}, 4'b0100);
      check("run_dirn", In_Dirn, 2'b00);
      for (int c = 1; c <= 12; c++) begin
         step();
         check($sformatf("tick_c%0d", c), Move_Tick, (c % 4) == 0);
         check($sformatf("scen_c%0d", c), SCEN, 1'b0);
      end
      press(4'b0001);
      press(4'b0100);
      wait_tick("rd_1", 2, 2'b11, 1'b1);
      wait_tick("rd_2", 4, 2'b01, 1'b1);
      press(4'b0010);
      wait_tick("to_l", 3, 2'b10, 1'b1);
      press(4'b1000);
      wait_tick("to_u", 3, 2'b00, 1'b1);
      press(4'b0100);
      wait_tick("opp_d", 3, 2'b00, 1'b0);
      press(4'b0010);
      press(4'b0001);
      press(4'b1000);
      wait_tick("lru_1", 1, 2'b10, 1'b1);
      wait_tick("lru_2", 4, 2'b00, 1'b1);
      wait_tick("lru_3", 4, 2'b00, 1'b0);
      press(4'b0010);
      press(4'b1000);
      press(4'b0001);
      wait_tick("full_1", 1, 2'b10, 1'b1);
      wait_tick("full_2", 4, 2'b00, 1'b1);
      wait_tick("full_3", 4, 2'b00, 1'b0);
      press(4'b0010);
      step();
      step();
      press(4'b0100);
      check("enq_deq", {Move_Tick, SCEN, In_Dirn}, 4'b1110);
      wait_tick("enq_deq_2", 4, 2'b01, 1'b1);
      press(4'b0001);
      wait_tick("to_r", 3, 2'b11, 1'b1);
      press(4'b1010);
      wait_tick("prio_1", 3, 2'b00, 1'b1);
      wait_tick("prio_2", 4, 2'b00, 1'b0);
      Length = 8'd5;
      step();
      Length = 8'd0;
      check("win_state", {q_I, q_Run, q_Win, q_Lose}, 4'b0010);
      for (int c = 0; c < 6; c++) begin
         step();
         check($sformatf("win_notick%0d", c), Move_Tick, 1'b0);
      end
      pulse_start();
      check("win_ack", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
      pulse_start();
      check("run2_state", {q_I, q_Run, q_Win, q_Lose}, 4'b0100);
      Collision = 1'b1;
      Length = 8'd5;
      step();
      Collision = 1'b0;
      Length = 8'd0;
      check("lose_state", {q_I, q_Run, q_Win, q_Lose}, 4'b0001);
      pulse_start();
      check("lose_ack", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
      pulse_start();
      press(4'b0001);
      wait_tick("run3_r", 3, 2'b11, 1'b1);
      press(4'b1000);
      Reset = 1'b1;
      #2;
      check("mid_rst_state", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
      check("mid_rst_out", {Move_Tick, SCEN, In_Dirn}, 4'b0000);
      step();
      Reset = 1'b0;
      pulse_start();
      wait_tick("post_rst", 4, 2'b00, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ee354_project_ctrl.md
Name: ee354_project_ctrl

Overview:
- Game controller sitting directly upstream of the snake length/position stage.
- Runs the top-level game state machine (I, Run, Win, Lose) and generates the periodic move strobe that paces the snake.
- Converts debounced direction-button pulses into a legal, queued direction stream (In_Dirn/SCEN) for the length stage.
- Consumes Length and Collision fed back from downstream.

Parameters:
- TICK_DIV, 25000000, clock cycles per snake move (4 moves/s at 100 MHz); must be >= 2
- CNT_W, 25, width of the move counter; must satisfy 2^CNT_W >= TICK_DIV
- WIN_LENGTH, 8'd225, snake length that ends the game as a win

Ports:
- Clk  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  one-cycle debounced pulse; starts the game or acknowledges Win/Lose
- Btn_U  input  1  one-cycle debounced pulse, request UP
- Btn_D  input  1  one-cycle debounced pulse, request DOWN
- Btn_L  input  1  one-cycle debounced pulse, request LEFT
- Btn_R  input  1  one-cycle debounced pulse, request RIGHT
- Length  input  8  current snake length from the length stage
- Collision  input  1  level from downstream; head hit wall or body
- q_I  output  1  one-hot state flag: Initial
- q_Run  output  1  one-hot state flag: Run
- q_Win  output  1  one-hot state flag: Win
- q_Lose  output  1  one-hot state flag: Lose
- Move_Tick  output  1  one-cycle strobe; snake advances one cell
- In_Dirn  output  2  committed direction: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
- SCEN  output  1  one-cycle strobe; In_Dirn changed this cycle

Behaviour:
- Reset (async) values:
  - state I: q_I=1, other state flags 0
  - Move_Tick=0, SCEN=0, In_Dirn=00
  - move counter 0, queue empty
- All outputs are registered.
- State transitions, evaluated every clock:
  - I -> Run on Start.
  - Run -> Lose on Collision. Collision has priority over win.
  - Run -> Win when Length >= WIN_LENGTH.
  - Win -> I on Start; Lose -> I on Start.
  - Start in Run is ignored.
- On I -> Run:
  - counter cleared to 0
  - queue cleared
  - In_Dirn forced to 00, matching the length stage's initial UP
- Move counter:
  - Counts only in Run.
  - When the counter equals TICK_DIV-1: Move_Tick=1 for exactly one cycle and the counter wraps to 0.
  - First Move_Tick occurs TICK_DIV cycles after the Run-entry clock.
  - Move_Tick is never asserted outside Run.
  - Leaving Run freezes the counter.
- Direction queue:
  - 2-entry FIFO of pending turns, active only in Run.
  - Button pulses outside Run are discarded.
- Simultaneous buttons: priority U > D > L > R; only one request is considered per cycle.
- Reference direction for a request:
  - the newest queue entry, after any same-cycle dequeue;
  - if the queue is empty, the current In_Dirn (or the entry being dequeued this cycle).
- A request is rejected if it equals the reference direction.
- A request is rejected if it is the opposite of the reference direction (same bit1, different bit0).
- A request is dropped if the queue is full after any same-cycle dequeue.
- Dequeue: on each Move_Tick with the queue non-empty:
  - In_Dirn <= head entry
  - SCEN=1 in the same cycle as Move_Tick
  - entry removed
- With an empty queue at Move_Tick, SCEN=0 and In_Dirn is unchanged.
- Enqueue and dequeue in the same cycle are both honoured; occupancy stays the same.
- Collision and Move_Tick in the same cycle: Lose wins, and Move_Tick is still emitted for that cycle.
- Reset asserted mid-game returns immediately to the reset values, regardless of state.

Test Plan (TICK_DIV=4, WIN_LENGTH=5):
- Reset then Start -> q_Run=1 next cycle, In_Dirn=00; Move_Tick pulses at cycles 4, 8, 12 after Start; SCEN=0.
- In Run, press Btn_R then Btn_D -> next tick: In_Dirn=11 with SCEN=1; following tick: In_Dirn=01 with SCEN=1.
- With In_Dirn=00, press Btn_D -> rejected, no SCEN at the next tick. Then Btn_L, Btn_R, Btn_U with no tick in between -> queue holds L then U; R is rejected as opposite of L.
- Fill the queue with L, U, then press Btn_R -> dropped; exactly two SCEN pulses on the next two ticks.
- Btn_U and Btn_L in the same cycle with In_Dirn=11 -> U accepted, L ignored.
- Length=5 in Run -> q_Win=1 next cycle, Move_Tick stays 0; Start -> q_I=1.
- Collision=1 and Length=5 in the same cycle -> q_Lose=1.
- Reset pulse mid-Run -> q_I=1, In_Dirn=00, queue empty.
